// File: rtl/dl_pkg.sv
// Shared helpers for the dl_pipe_reg elastic pipeline slice.
package dl_pkg;

    // Width of a counter that has to hold every value from 0 to n inclusive.
    function automatic int CNT_W(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : dl_pkg

// File: rtl/dl_pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a data register, and the
// local link of the ready chain (an empty stage is always ready).
module dl_pipe_stage
    import dl_pkg::*;
#(
    parameter int unsigned           NUM_BITS  = 32,
    parameter logic [NUM_BITS-1:0]   RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                up_valid,
    input  logic [NUM_BITS-1:0] up_data,
    input  logic                down_ready,
    output logic                valid,
    output logic [NUM_BITS-1:0] data,
    output logic                rdy
);

    // Bubble collapsing: an empty slot accepts regardless of downstream.
    always_comb begin
        rdy = !valid || down_ready;
    end

    // Valid bit: reset and flush clear it, otherwise it follows upstream
    // whenever this stage is allowed to advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (rdy) begin
            valid <= up_valid;
        end
    end

    // Data register: only loads real data, so it holds across bubbles and
    // across a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= RESET_VAL;
        end else if (!flush && rdy && up_valid) begin
            data <= up_data;
        end
    end

endmodule : dl_pipe_stage

// File: rtl/dl_pipe_reg.sv
// Multi-stage elastic pipeline register with valid/ready on both sides,
// bubble collapsing, synchronous flush and a registered occupancy count.
module dl_pipe_reg
    import dl_pkg::*;
#(
    parameter int unsigned           NUM_BITS   = 32,
    parameter int unsigned           NUM_STAGES = 2,
    parameter logic [NUM_BITS-1:0]   RESET_VAL  = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_BITS-1:0]               in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_BITS-1:0]               out_data,
    output logic [CNT_W(NUM_STAGES)-1:0]      count
);

    localparam int CW = CNT_W(NUM_STAGES);

    if (NUM_STAGES < 1) begin : g_bad_depth
        $error("dl_pipe_reg: NUM_STAGES must be at least 1");
    end

    logic [NUM_STAGES-1:0] valid_vec;
    logic                  in_xfer;
    logic                  out_xfer;
    logic [CW-1:0]         count_next;

    // Each stage keeps its neighbour links in its own generate scope; the
    // ready chain runs from the last stage back to stage 0, so keeping the
    // links as separate scalars avoids one vector that feeds itself.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic                stage_valid;
        logic [NUM_BITS-1:0] stage_data;
        logic                stage_rdy;
        logic                up_valid;
        logic [NUM_BITS-1:0] up_data;
        logic                down_ready;

        if (k == 0) begin : g_first
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_inner_up
            assign up_valid = g_stage[k-1].stage_valid;
            assign up_data  = g_stage[k-1].stage_data;
        end

        if (k == NUM_STAGES - 1) begin : g_last
            assign down_ready = out_ready;
        end else begin : g_inner_down
            assign down_ready = g_stage[k+1].stage_rdy;
        end

        dl_pipe_stage #(
            .NUM_BITS  (NUM_BITS),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .down_ready (down_ready),
            .valid      (stage_valid),
            .data       (stage_data),
            .rdy        (stage_rdy)
        );

        assign valid_vec[k] = stage_valid;
    end

    // Port glue: input side gated by flush, output side is the last stage.
    always_comb begin
        in_ready  = g_stage[0].stage_rdy && !flush;
        out_valid = g_stage[NUM_STAGES-1].stage_valid;
        out_data  = g_stage[NUM_STAGES-1].stage_data;
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
    end

    // Occupancy bookkeeping: one in and one out in the same cycle cancel.
    always_comb begin
        count_next = count;
        if (in_xfer && !out_xfer) begin
            count_next = count + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            count_next = count - CW'(1);
        end
    end

    // Occupancy register: cleared by reset and by flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    a_count_matches_valid : assert property (
        @(posedge clk) disable iff (rst)
        count == CW'($countones(valid_vec))
    );

    a_full_stall_blocks_input : assert property (
        @(posedge clk) disable iff (rst)
        (&valid_vec && !out_ready) |-> !in_ready
    );

endmodule : dl_pipe_reg

// File: tb/tb_dl_pipe_reg.sv
// Self-checking bench for dl_pipe_reg (3 stages, 32-bit data, reset value 0).
module tb_dl_pipe_reg;

    localparam int N = 3;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  count;

    int n_pass;
    int n_total;
    bit mon_en;

    logic [31:0] sb [$];

    dl_pipe_reg #(
        .NUM_BITS   (32),
        .NUM_STAGES (N),
        .RESET_VAL  (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: model count/in_ready from the queue, push accepted
    // words, pop and compare delivered words.
    always @(negedge clk) begin
        logic        exp_ir;
        logic [31:0] exp_d;
        if (mon_en) begin
            exp_ir = !flush && ((sb.size() < N) || out_ready);
            n_total++;
            if (in_ready !== exp_ir) $display("FAIL mon_in_ready: got %b want %b", in_ready, exp_ir);
            else n_pass++;
            n_total++;
            if (count !== 2'(sb.size())) $display("FAIL mon_count: got %0d want %0d", count, sb.size());
            else n_pass++;
            if (rst) begin
                sb.delete();
            end else begin
                if (out_valid === 1'b1 && out_ready) begin
                    n_total++;
                    if (sb.size() == 0) begin
                        $display("FAIL mon_unexpected_out: got %h want no output", out_data);
                    end else begin
                        exp_d = sb.pop_front();
                        if (out_data !== exp_d) $display("FAIL mon_out_data: got %h want %h", out_data, exp_d);
                        else n_pass++;
                    end
                end
                if (flush) sb.delete();
                else if (in_valid && in_ready) sb.push_back(in_data);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1;
        next_cycle();
        mon_en = 1'b1;
        next_cycle();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 0", out_data);
        else n_pass++;
        n_total++;
        if (count !== 2'd0) $display("FAIL reset_count: got %0d want 0", count);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 32'(i + 1); out_ready = 1'b1;
            @(negedge clk);
            n_total++;
            if (out_valid !== (i >= 3)) $display("FAIL stream_out_valid[%0d]: got %b want %b", i, out_valid, (i >= 3));
            else n_pass++;
            if (i >= 3) begin
                n_total++;
                if (out_data !== 32'(i - 2)) $display("FAIL stream_out_data[%0d]: got %h want %h", i, out_data, 32'(i - 2));
                else n_pass++;
            end
            n_total++;
            if (count !== 2'((i < 3) ? i : 3)) $display("FAIL stream_count[%0d]: got %0d want %0d", i, count, (i < 3) ? i : 3);
            else n_pass++;
            next_cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (out_data !== 32'(8 + i)) $display("FAIL stream_drain_data[%0d]: got %h want %h", i, out_data, 32'(8 + i));
            else n_pass++;
            next_cycle();
        end
        @(negedge clk);
        n_total++;
        if (count !== 2'd0) $display("FAIL stream_empty_count: got %0d want 0", count);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [31:0] pushes [3];
        pushes[0] = 32'hA; pushes[1] = 32'hB; pushes[2] = 32'hC;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = pushes[i];
            @(negedge clk);
            n_total++;
            if (in_ready !== 1'b1) $display("FAIL bp_fill_in_ready[%0d]: got %b want 1", i, in_ready);
            else n_pass++;
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if (count !== 2'd3) $display("FAIL bp_full_count: got %0d want 3", count);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready: got %b want 0", in_ready);
        else n_pass++;
        n_total++;
        if (out_data !== 32'hA) $display("FAIL bp_full_out_data: got %h want a", out_data);
        else n_pass++;
        next_cycle();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hD;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL bp_swap_in_ready: got %b want 1", in_ready);
        else n_pass++;
        next_cycle();
        out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if (out_data !== 32'hB) $display("FAIL bp_after_swap_data: got %h want b", out_data);
        else n_pass++;
        n_total++;
        if (count !== 2'd3) $display("FAIL bp_after_swap_count: got %0d want 3", count);
        else n_pass++;
        next_cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (out_data !== 32'(32'hB + i)) $display("FAIL bp_drain_data[%0d]: got %h want %h", i, out_data, 32'(32'hB + i));
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_bubble_collapse();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h55; exp_seq[1] = 32'h66; exp_seq[2] = 32'h77;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
        next_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) next_cycle();
        for (int i = 1; i < 3; i++) begin
            in_valid = 1'b1; in_data = exp_seq[i];
            @(negedge clk);
            n_total++;
            if (in_ready !== 1'b1) $display("FAIL bubble_in_ready[%0d]: got %b want 1", i, in_ready);
            else n_pass++;
            n_total++;
            if (count !== 2'(i)) $display("FAIL bubble_count[%0d]: got %0d want %0d", i, count, i);
            else n_pass++;
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if (count !== 2'd3) $display("FAIL bubble_full_count: got %0d want 3", count);
        else n_pass++;
        next_cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (out_valid !== 1'b1 || out_data !== exp_seq[i])
                $display("FAIL bubble_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_seq[i]);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 32'(32'h10 + i);
            next_cycle();
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h99;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready);
        else n_pass++;
        next_cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_total++;
                if (count !== 2'd0) $display("FAIL flush_count: got %0d want 0", count);
                else n_pass++;
            end
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL flush_out_valid[%0d]: got %b want 0", i, out_valid);
            else n_pass++;
            next_cycle();
        end
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h20;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        next_cycle();
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 32'h20)
            $display("FAIL flush_last_out: got v=%b d=%h want v=1 d=20", out_valid, out_data);
        else n_pass++;
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0 || count !== 2'd0)
            $display("FAIL flush_after_out: got v=%b cnt=%0d want v=0 cnt=0", out_valid, count);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'(i + 1);
            next_cycle();
        end
        rst = 1'b1; flush = 1'b1; in_valid = 1'b0;
        next_cycle();
        rst = 1'b0; flush = 1'b0;
        for (int j = 0; j < 4; j++) begin
            in_valid = (j == 0); in_data = 32'h4; out_ready = 1'b1;
            @(negedge clk);
            if (j == 0) begin
                n_total++;
                if (count !== 2'd0) $display("FAIL rstmid_count: got %0d want 0", count);
                else n_pass++;
                n_total++;
                if (out_data !== 32'h0) $display("FAIL rstmid_out_data: got %h want 0", out_data);
                else n_pass++;
            end
            n_total++;
            if (out_valid !== (j == 3)) $display("FAIL rstmid_out_valid[%0d]: got %b want %b", j, out_valid, (j == 3));
            else n_pass++;
            if (j == 3) begin
                n_total++;
                if (out_data !== 32'h4) $display("FAIL rstmid_push_data: got %h want 4", out_data);
                else n_pass++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        next_cycle();
    endtask

    initial begin
        n_pass = 0; n_total = 0; mon_en = 1'b0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble_collapse();
        test_flush();
        test_reset_mid();
        n_total++;
        if (sb.size() != 0) $display("FAIL final_scoreboard_empty: got %0d entries want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dl_pipe_reg
